// File: rtl/fp_pipe_tracker.sv
// fp_pipe_tracker: control-side shadow of the FP execute pipeline.
// Tracks {dest reg, write enable, unit code} through NSTAGE execute
// stages plus writeback, runs the fdiv/fsqrt stall countdown and
// resolves RAW hazards for the FP issue stage (stall or forward).
//
// Ports:
//   clk, clrn          clock, async active-low reset
//   en                 pipeline advance (0 freezes all state)
//   issue_v/fd/wf/fc   op presented at issue
//   cancel1            kill the write of the stage-1 op
//   src_a/b, *_fp      issue-stage sources and FP-regfile flags
//   st_ds, iter_cnt    iterative-unit stall and its countdown
//   stage_n/w/c        per-stage tags, stage 1 in the LSBs
//   wb_n/w/c           writeback tags
//   fwd_a/b            0 regfile, 1 final stage, 2 writeback
//   raw_stall          RAW hazard stall
module fp_pipe_tracker #(
    parameter int NSTAGE   = 3,
    parameter int RW       = 5,
    parameter int CW       = 2,
    parameter int ITER_CYC = 14
) (
    input  logic                 clk,
    input  logic                 clrn,
    input  logic                 en,
    input  logic                 issue_v,
    input  logic [RW-1:0]        issue_fd,
    input  logic                 issue_wf,
    input  logic [CW-1:0]        issue_fc,
    input  logic                 cancel1,
    input  logic [RW-1:0]        src_a,
    input  logic [RW-1:0]        src_b,
    input  logic                 src_a_fp,
    input  logic                 src_b_fp,
    output logic                 st_ds,
    output logic [7:0]           iter_cnt,
    output logic [NSTAGE*RW-1:0] stage_n,
    output logic [NSTAGE-1:0]    stage_w,
    output logic [NSTAGE*CW-1:0] stage_c,
    output logic [RW-1:0]        wb_n,
    output logic                 wb_w,
    output logic [CW-1:0]        wb_c,
    output logic [1:0]           fwd_a,
    output logic [1:0]           fwd_b,
    output logic                 raw_stall
);

    localparam logic [7:0] LP_ITER = 8'(ITER_CYC);

    logic [NSTAGE-1:0][RW-1:0] r_n;
    logic [NSTAGE-1:0]         r_w;
    logic [NSTAGE-1:0][CW-1:0] r_c;
    logic [RW-1:0]             r_wb_n;
    logic                      r_wb_w;
    logic [CW-1:0]             r_wb_c;
    logic [7:0]                r_cnt;

    logic [NSTAGE-1:0] w_ew;
    logic              w_is_iter;
    logic              w_acc;
    logic              w_sa;
    logic              w_sb;
    logic [1:0]        w_fa;
    logic [1:0]        w_fb;

    // Only stage 1 can be cancelled; the masked bit is also what shifts on.
    assign w_ew = r_w & ~{{(NSTAGE-1){1'b0}}, cancel1};

    assign w_is_iter = issue_v & issue_fc[1];
    // Stall holds until the countdown reaches its last count.
    assign st_ds     = clrn & w_is_iter & (r_cnt != 8'd1);
    assign w_acc     = issue_v & ~st_ds & ~raw_stall;

    // Oldest match is applied first so younger stages override it.
    always_comb begin
        w_sa = 1'b0;
        w_sb = 1'b0;
        w_fa = 2'd0;
        w_fb = 2'd0;
        if (src_a_fp && r_wb_w && (r_wb_n == src_a))
            w_fa = 2'd2;
        if (src_b_fp && r_wb_w && (r_wb_n == src_b))
            w_fb = 2'd2;
        if (src_a_fp && w_ew[NSTAGE-1] && (r_n[NSTAGE-1] == src_a))
            w_fa = 2'd1;
        if (src_b_fp && w_ew[NSTAGE-1] && (r_n[NSTAGE-1] == src_b))
            w_fb = 2'd1;
        for (int i = 0; i < NSTAGE - 1; i++) begin
            if (src_a_fp && w_ew[i] && (r_n[i] == src_a))
                w_sa = 1'b1;
            if (src_b_fp && w_ew[i] && (r_n[i] == src_b))
                w_sb = 1'b1;
        end
        if (w_sa)
            w_fa = 2'd0;
        if (w_sb)
            w_fb = 2'd0;
    end

    assign raw_stall = issue_v & (w_sa | w_sb);
    assign fwd_a     = w_fa;
    assign fwd_b     = w_fb;

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_cnt <= 8'd0;
        end else if (en) begin
            if (r_cnt == 8'd0) begin
                if (w_is_iter)
                    r_cnt <= LP_ITER;
            end else begin
                r_cnt <= r_cnt - 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_n    <= '0;
            r_w    <= '0;
            r_c    <= '0;
            r_wb_n <= '0;
            r_wb_w <= 1'b0;
            r_wb_c <= '0;
        end else if (en) begin
            r_n[0] <= w_acc ? issue_fd : '0;
            r_w[0] <= w_acc & issue_wf;
            r_c[0] <= w_acc ? issue_fc : '0;
            for (int i = 1; i < NSTAGE; i++) begin
                r_n[i] <= r_n[i-1];
                r_w[i] <= w_ew[i-1];
                r_c[i] <= r_c[i-1];
            end
            r_wb_n <= r_n[NSTAGE-1];
            r_wb_w <= w_ew[NSTAGE-1];
            r_wb_c <= r_c[NSTAGE-1];
        end
    end

    assign iter_cnt = r_cnt;
    assign stage_n  = r_n;
    assign stage_w  = w_ew;
    assign stage_c  = r_c;
    assign wb_n     = r_wb_n;
    assign wb_w     = r_wb_w;
    assign wb_c     = r_wb_c;

endmodule

// File: tb/tb_fp_pipe_tracker.sv
// tb_fp_pipe_tracker: directed stimulus with a writeback scoreboard.
// Accepted ops are queued with their expected writeback cycle.
module tb_fp_pipe_tracker;

    localparam int NS = 3;

    logic          clk = 1'b0;
    logic          clrn = 1'b0;
    logic          en = 1'b1;
    logic          issue_v = 1'b0;
    logic [4:0]    issue_fd = '0;
    logic          issue_wf = 1'b0;
    logic [1:0]    issue_fc = '0;
    logic          cancel1 = 1'b0;
    logic [4:0]    src_a = '0;
    logic [4:0]    src_b = '0;
    logic          src_a_fp = 1'b0;
    logic          src_b_fp = 1'b0;
    logic          st_ds;
    logic [7:0]    iter_cnt;
    logic [14:0]   stage_n;
    logic [2:0]    stage_w;
    logic [5:0]    stage_c;
    logic [4:0]    wb_n;
    logic          wb_w;
    logic [1:0]    wb_c;
    logic [1:0]    fwd_a;
    logic [1:0]    fwd_b;
    logic          raw_stall;

    fp_pipe_tracker #(
        .NSTAGE(NS), .RW(5), .CW(2), .ITER_CYC(14)
    ) dut (
        .clk(clk), .clrn(clrn), .en(en),
        .issue_v(issue_v), .issue_fd(issue_fd),
        .issue_wf(issue_wf), .issue_fc(issue_fc),
        .cancel1(cancel1),
        .src_a(src_a), .src_b(src_b),
        .src_a_fp(src_a_fp), .src_b_fp(src_b_fp),
        .st_ds(st_ds), .iter_cnt(iter_cnt),
        .stage_n(stage_n), .stage_w(stage_w), .stage_c(stage_c),
        .wb_n(wb_n), .wb_w(wb_w), .wb_c(wb_c),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .raw_stall(raw_stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] n;
        logic [1:0] c;
        int         at;
    } exp_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   ecnt = 0;
    logic adv = 1'b0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        adv <= en & clrn;
        if (clrn && en)
            ecnt <= ecnt + 1;
    end

    always @(negedge clk) begin
        if (clrn && adv && wb_w) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL wb_unexpected: got wb_n=%0d required none",
                         wb_n);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("wb_n", 64'(wb_n), 64'(e.n));
                chk("wb_c", 64'(wb_c), 64'(e.c));
                chk("wb_latency", 64'(ecnt), 64'(e.at));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [4:0] fd, input logic wf,
                         input logic [1:0] fc);
        issue_v  = 1'b1;
        issue_fd = fd;
        issue_wf = wf;
        issue_fc = fc;
    endtask

    task automatic idle();
        issue_v = 1'b0;
    endtask

    task automatic push(input logic [4:0] fd, input logic [1:0] fc);
        exp_t e;
        e.n  = fd;
        e.c  = fc;
        e.at = ecnt + NS + 1;
        sb.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int stall;
        // reset state
        #3;
        chk("rst_outputs",
            64'({st_ds, iter_cnt, stage_n, stage_w, stage_c,
                 wb_n, wb_w, wb_c, fwd_a, fwd_b, raw_stall}), 64'd0);
        #4 clrn = 1'b1;
        cyc();

        // single add walks the pipe
        issue(5'd7, 1'b1, 2'd0);
        push(5'd7, 2'd0);
        #1;
        chk("add_no_stall", 64'({raw_stall, st_ds}), 64'd0);
        cyc();
        idle();
        #1;
        chk("add_s1_w", 64'(stage_w), 64'b001);
        chk("add_s1_n", 64'(stage_n[4:0]), 64'd7);
        cyc();
        chk("add_s2_w", 64'(stage_w), 64'b010);
        cyc();
        chk("add_s3_w", 64'(stage_w), 64'b100);
        cyc();
        chk("add_wb", 64'({wb_w, wb_n}), 64'({1'b1, 5'd7}));
        cyc();

        // RAW: stall twice, then forward from final stage, then writeback
        issue(5'd3, 1'b1, 2'd1);
        push(5'd3, 2'd1);
        cyc();
        issue(5'd10, 1'b1, 2'd0);
        src_a = 5'd3;
        src_a_fp = 1'b1;
        #1;
        chk("raw_s1", 64'(raw_stall), 64'd1);
        cyc();
        chk("raw_s2", 64'(raw_stall), 64'd1);
        cyc();
        chk("raw_s3", 64'({raw_stall, fwd_a}), 64'({1'b0, 2'd1}));
        push(5'd10, 2'd0);
        cyc();
        issue(5'd11, 1'b1, 2'd0);
        #1;
        chk("raw_wb", 64'({raw_stall, fwd_a}), 64'({1'b0, 2'd2}));
        push(5'd11, 2'd0);
        cyc();
        idle();
        src_a_fp = 1'b0;
        repeat (3) cyc();

        // non-FP source never matches; src_b hazard; issue_v gating
        issue(5'd3, 1'b1, 2'd1);
        push(5'd3, 2'd1);
        cyc();
        issue(5'd12, 1'b1, 2'd0);
        src_a = 5'd3;
        src_a_fp = 1'b0;
        #1;
        chk("nofp_a", 64'({raw_stall, fwd_a}), 64'd0);
        push(5'd12, 2'd0);
        cyc();
        issue(5'd13, 1'b1, 2'd0);
        src_b = 5'd12;
        src_b_fp = 1'b1;
        #1;
        chk("raw_b", 64'(raw_stall), 64'd1);
        idle();
        #1;
        chk("raw_gated", 64'(raw_stall), 64'd0);
        src_b_fp = 1'b0;
        repeat (5) cyc();

        // youngest match wins: stage 3 over writeback
        issue(5'd5, 1'b1, 2'd1);
        push(5'd5, 2'd1);
        cyc();
        issue(5'd5, 1'b1, 2'd1);
        push(5'd5, 2'd1);
        cyc();
        idle();
        cyc();
        cyc();
        src_a = 5'd5;
        src_a_fp = 1'b1;
        src_b = 5'd5;
        src_b_fp = 1'b1;
        #1;
        chk("young_a", 64'(fwd_a), 64'd1);
        chk("young_b", 64'(fwd_b), 64'd1);
        cyc();
        chk("young_wb", 64'(fwd_b), 64'd2);
        cyc();
        chk("young_none", 64'(fwd_b), 64'd0);
        src_a_fp = 1'b0;
        src_b_fp = 1'b0;

        // cancel of stage-1 op
        issue(5'd9, 1'b1, 2'd0);
        cyc();
        idle();
        #1;
        chk("cancel_pre", 64'(stage_w), 64'b001);
        cancel1 = 1'b1;
        #1;
        chk("cancel_s1", 64'(stage_w), 64'b000);
        cyc();
        cancel1 = 1'b0;
        #1;
        chk("cancel_s2", 64'(stage_w), 64'b000);
        repeat (4) cyc();

        // divide: 14 stall cycles, counter 0 then 14..2
        issue(5'd4, 1'b1, 2'd2);
        stall = 0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (!st_ds)
                break;
            chk("div_cnt", 64'(iter_cnt),
                64'((k == 0) ? 0 : 15 - k));
            stall++;
            cyc();
        end
        chk("div_stall_len", 64'(stall), 64'd14);
        chk("div_cnt_last", 64'(iter_cnt), 64'd1);
        push(5'd4, 2'd2);
        cyc();
        idle();
        #1;
        chk("div_s1", 64'({stage_w[0], stage_c[1:0], stage_n[4:0]}),
            64'({1'b1, 2'd2, 5'd4}));
        chk("div_cnt_idle", 64'(iter_cnt), 64'd0);

        // sqrt with a 5-cycle freeze in the middle
        issue(5'd6, 1'b1, 2'd3);
        stall = 0;
        for (int t = 0; t < 60; t++) begin
            #1;
            if (!st_ds)
                break;
            stall++;
            if (t == 10)
                chk("freeze_hold", 64'(iter_cnt), 64'd10);
            en = !(t >= 5 && t < 10);
            cyc();
        end
        en = 1'b1;
        chk("freeze_stall_len", 64'(stall), 64'd19);
        push(5'd6, 2'd3);
        cyc();
        idle();
        repeat (5) cyc();

        // async reset with every stage and writeback occupied
        issue(5'd30, 1'b1, 2'd0);
        cyc();
        issue(5'd31, 1'b1, 2'd0);
        cyc();
        issue(5'd32, 1'b1, 2'd1);
        cyc();
        issue(5'd33, 1'b1, 2'd0);
        cyc();
        idle();
        #1;
        chk("full_pipe", 64'({wb_w, stage_w}), 64'b1111);
        clrn = 1'b0;
        #1;
        chk("rst_full",
            64'({stage_n, stage_w, stage_c, wb_n, wb_w, wb_c}), 64'd0);
        #1 clrn = 1'b1;
        cyc();

        // async reset mid-countdown
        issue(5'd8, 1'b1, 2'd2);
        for (int k = 0; k < 30; k++) begin
            cyc();
            if (iter_cnt == 8'd6)
                break;
        end
        chk("pre_rst_cnt", 64'(iter_cnt), 64'd6);
        clrn = 1'b0;
        #1;
        chk("rst_cnt",
            64'({st_ds, iter_cnt, stage_w, wb_w, raw_stall}), 64'd0);
        idle();
        #1 clrn = 1'b1;
        cyc();
        chk("post_rst", 64'({st_ds, iter_cnt}), 64'd0);

        repeat (6) cyc();
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_pipe_tracker.md
Name: fp_pipe_tracker

Overview:
- Parametrised control tracker for the floating-point execution pipeline.
- Carries destination register number, write-enable and unit code through NSTAGE execute stages plus a writeback stage.
- Generates the iterative-unit (fdiv/fsqrt) stall, including its countdown, and the RAW-hazard stall/forward selects for the FP issue stage.
- Sits beside the FP datapath. The datapath muxes results using this block's final-stage unit code and writeback tags.

Parameters:
- NSTAGE, 3, number of execute stages (legal 2..8).
- RW, 5, register-number width.
- CW, 2, unit-code width. Code 0 add/sub, 1 mul, 2 div, 3 sqrt. A code with bit1 set is iterative.
- ITER_CYC, 14, stall cycles per iterative op (legal 1..255).

Ports:
- clk  in  1  clock
- clrn  in  1  reset
- en  in  1  pipeline advance (0 = no_cache_stall freeze)
- issue_v  in  1  valid FP op at issue
- issue_fd  in  RW  destination register
- issue_wf  in  1  op writes FP regfile
- issue_fc  in  CW  unit code
- cancel1  in  1  kill write of stage-1 op
- src_a, src_b  in  RW  issue-stage source registers
- src_a_fp, src_b_fp  in  1  source reads FP regfile
- st_ds  out  1  iterative-unit stall
- iter_cnt  out  8  countdown value (test visibility)
- stage_n  out  NSTAGE*RW  per-stage register numbers, stage 1 in LSBs
- stage_w  out  NSTAGE  per-stage effective write enables
- stage_c  out  NSTAGE*CW  per-stage unit codes
- wb_n  out  RW  writeback register number
- wb_w  out  1  writeback write enable
- wb_c  out  CW  writeback unit code
- fwd_a, fwd_b  out  2  forward select: 0 regfile, 1 final-stage result, 2 writeback result
- raw_stall  out  1  RAW hazard stall

Behaviour:
- Reset: clrn is asynchronous, active-low; clock is clk.
- While clrn = 0: all stage and writeback registers are 0 and iter_cnt = 0. All outputs are 0 except fwd selects, which are 0 because no stage is valid.
- Reset mid-countdown aborts the countdown. st_ds is 0 after release unless a new iterative issue is present.
- Advance: when en = 1, every stage shifts one position and stage NSTAGE moves into writeback. When en = 0, all state holds, including iter_cnt.
- Stage-1 load when en = 1:
  - If issue_v & ~st_ds & ~raw_stall: stage 1 takes {issue_fd, issue_wf, issue_fc}.
  - Otherwise stage 1 takes a bubble {0, 0, 0}.
- Cancel: stage_w[0] output = stored w & ~cancel1. The value shifted into stage 2 uses the same masked w, so a cancelled op never writes.
- Latency: an accepted op appears on wb_* exactly NSTAGE+1 enabled cycles after acceptance.
- Iterative counter:
  - is_iter = issue_v & issue_fc[1].
  - st_ds = is_iter & (iter_cnt != 1).
  - Idle (cnt = 0), is_iter and en: cnt <= ITER_CYC.
  - cnt > 1 and en: cnt <= cnt - 1.
  - cnt = 1 and en: the op is accepted and cnt <= 0.
  - Net effect: st_ds is high for exactly ITER_CYC enabled cycles, then the op enters stage 1.
  - ITER_CYC = 1 gives a single stall cycle.
  - If issue_v drops while counting, the counter keeps running down to 0 with no acceptance. The abort is the issuer's responsibility.
- Hazard detection, per source with its _fp flag set:
  - Compare against stages 1..NSTAGE (effective w) and writeback (wb_w).
  - The youngest match wins.
  - Youngest match in stages 1..NSTAGE-1: raw_stall = 1.
  - Youngest match in stage NSTAGE: fwd = 1.
  - Youngest match in writeback: fwd = 2.
  - No match: fwd = 0.
  - A source with _fp = 0 never matches.
  - Register 0 is an ordinary FP register.
- raw_stall is the OR over both sources, gated by issue_v. st_ds and raw_stall may assert together. Either one blocks acceptance.

Test Plan:
- Single add, NSTAGE=3: issue fd=7, wf=1, fc=0, en=1 -> stage_w walks 001,010,100, then wb_n=7, wb_w=1 on the 4th cycle after acceptance.
- Div, ITER_CYC=14: issue fc=2 fd=4 held -> st_ds=1 for 14 cycles, iter_cnt 14..1, op enters stage 1 on cycle 15. Drop en for 5 cycles mid-count -> stall stretches to 19 cycles.
- RAW: op fd=3 accepted, next op src_a=3 src_a_fp=1 -> raw_stall=1 for 2 cycles, then fwd_a=1 for 1 cycle (accepted), follow-up src_a=3 gives fwd_a=2. Same case with src_a_fp=0 -> no stall, fwd_a=0.
- Youngest wins: fd=5 in writeback and fd=5 in stage NSTAGE -> fwd_a=1.
- Cancel: cancel1=1 while fd=9 is in stage 1 -> stage_w[0]=0 and wb_w never asserts for that op.
- Reset: clrn low at iter_cnt=6 with ops in all stages -> all outputs 0 immediately (asynchronous). After release with no issue: st_ds=0, iter_cnt=0.
